fetch_unit: RTL and testbench
=============================

# fetch_unit

Parametrised instruction-fetch stage for the fetch/decode/execute pipeline. It holds a loadable instruction memory, maintains the program counter and presents `{pc, instr}` to decode through a valid/stall handshake. It accepts same-cycle branch redirects from writeback, stops fetching on HLT and flags out-of-range PCs. Sits between the writeback redirect path and the decode stage.

## Interface
- `PC_W`, default 32: program counter width (word address).
- `INSTR_W`, default 32: instruction width.
- `DEPTH`, default 128: instruction memory words; power of two, at least 2.
- `OPC_W`, default 6: opcode field width, taken from `instr[INSTR_W-1 -: OPC_W]`.
- `HLT_OPC`, default 6'b001101: opcode that halts fetch.
- `NOP_WORD`, default 32'h3800_0000: word issued in place of out-of-range fetches.

Ports:
- `clock` in 1: clock, rising edge.
- `reset` in 1: synchronous, active-low.
- `stall` in 1: decode not ready; hold the IF/ID register and PC.
- `redirect_valid` in 1: branch taken, from EX/WB.
- `redirect_pc` in PC_W: branch target.
- `imem_we` in 1: program-load write enable.
- `imem_waddr` in $clog2(DEPTH): write address.
- `imem_wdata` in INSTR_W: write data.
- `if_id_valid` out 1: IF/ID register holds a live instruction.
- `if_id_pc` out PC_W: PC of the held instruction.
- `if_id_instr` out INSTR_W: held instruction.
- `pc` out PC_W: next PC to fetch.
- `halted` out 1: HLT fetched; fetch stopped.
- `pc_fault` out 1: sticky flag; a PC >= DEPTH was fetched.

## Operation
- States: RUN, HALT.
  - Reset goes to RUN.
  - RUN goes to HALT when an instruction with opcode == HLT_OPC is loaded into IF/ID.
  - HALT is left by `redirect_valid` (goes to RUN) or by reset.
- Priority each cycle in RUN: reset, then redirect, then stall, then sequential.
- Redirect: fetch from `redirect_pc` in the same cycle.
  - IF/ID <= {redirect_pc, mem[redirect_pc]}, valid = 1.
  - pc <= redirect_pc + 1.
  - Redirect overrides `stall`. The stalled instruction is squashed.
- Stall, no redirect: IF/ID, `if_id_valid` and `pc` all hold.
- Sequential: IF/ID <= {pc, mem[pc]}, valid = 1, pc <= pc + 1.
- HALT: no fetch and pc holds.
  - `if_id_valid` drops to 0 on the first non-stalled cycle after the HLT has been held.
  - The HLT itself is presented once.
- Out of range (fetch PC >= DEPTH): issue NOP_WORD with the true PC and valid = 1, and set `pc_fault`. Fetch continues.
- PC arithmetic is modulo 2^PC_W. At all-ones the PC wraps to 0 and is not an error.
- Instruction memory:
  - Asynchronous read, synchronous write.
  - A write to the address being fetched in the same cycle returns the old word.
  - Writes are accepted in any state, including during reset.
- The memory is not cleared by reset. Its initial contents are X unless loaded.

## Timing
- Reset values:
  - `pc` = 0, `if_id_valid` = 0, `if_id_pc` = 0, `if_id_instr` = NOP_WORD.
  - `halted` = 0, `pc_fault` = 0.
  - State = RUN.
- The first fetch takes place on the first rising edge with reset high. `if_id_valid` is 1 after that edge.
- Fetch latency is 1 cycle: the address is presented at edge N and the instruction is at IF/ID after edge N.
- Redirect latency is 1 cycle: the target instruction is valid after the edge that samples `redirect_valid`, with no bubble.
- `halted` rises on the same edge that loads HLT into IF/ID.
- Reset asserted mid-stream or during a stall wins over everything else; all outputs take their reset values on that edge.
- All outputs are registered except `pc`, which is the PC register itself.

## Test plan
- Sequential fetch: load words 0..4 with distinct values, release reset, no stall.
  - Required: IF/ID shows (0,w0),(1,w1)..(4,w4) on consecutive cycles, with pc one ahead of IF/ID.
- Stall: assert `stall` for 3 cycles while IF/ID = (2,w2).
  - Required: IF/ID and pc = 3 hold for 3 cycles, then (3,w3) follows.
- Redirect during stall: stall held, `redirect_valid`=1, `redirect_pc`=9.
  - Required: next IF/ID = (9,w9), pc = 10, and the stalled (2,w2) is never re-presented.
- Halt: place HLT at address 5.
  - Required: `halted`=1 with IF/ID = (5,HLT), then valid=0 the following cycle and pc stays 6.
  - A redirect to 0 then resumes fetch with (0,w0) and `halted`=0.
- Out of range: DEPTH=8, run to pc=8.
  - Required: IF/ID = (8,NOP_WORD), valid=1, `pc_fault`=1 and sticky, pc=9.
- Reset mid-run: assert reset while pc=7 and halted.
  - Required: after one edge pc=0, valid=0, halted=0, pc_fault=0, and memory contents are intact.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: loadable instruction memory, program counter and the
// IF/ID register presented to decode, with branch redirect, halt and PC fault tracking.
module fetch_unit #(
    parameter int                 PC_W     = 32,
    parameter int                 INSTR_W  = 32,
    parameter int                 DEPTH    = 128,
    parameter int                 OPC_W    = 6,
    parameter logic [OPC_W-1:0]   HLT_OPC  = 6'b001101,
    parameter logic [INSTR_W-1:0] NOP_WORD = 32'h3800_0000
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     stall,
    input  logic                     redirect_valid,
    input  logic [PC_W-1:0]          redirect_pc,
    input  logic                     imem_we,
    input  logic [$clog2(DEPTH)-1:0] imem_waddr,
    input  logic [INSTR_W-1:0]       imem_wdata,
    output logic                     if_id_valid,
    output logic [PC_W-1:0]          if_id_pc,
    output logic [INSTR_W-1:0]       if_id_instr,
    output logic [PC_W-1:0]          pc,
    output logic                     halted,
    output logic                     pc_fault
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic {RUN, HALT} state_t;

    state_t             state;
    logic [INSTR_W-1:0] mem [DEPTH];

    logic [PC_W-1:0]    fetch_pc;
    logic               fetch_oor;
    logic [INSTR_W-1:0] fetch_word;
    logic               fetch_hlt;
    logic               do_fetch;

    // NOTE: the memory array has no reset branch on purpose; program contents must
    // survive reset, and a reset-free array maps cleanly onto RAM.
    always_ff @(posedge clock) begin
        if (imem_we) begin
            mem[imem_waddr] <= imem_wdata;
        end
    end

    // Redirect target replaces the sequential PC in the same cycle, so the branch
    // target is fetched with no bubble.
    assign fetch_pc   = redirect_valid ? redirect_pc : pc;
    assign fetch_oor  = fetch_pc >= PC_W'(DEPTH);
    assign fetch_word = fetch_oor ? NOP_WORD : mem[fetch_pc[AW-1:0]];
    assign fetch_hlt  = fetch_word[INSTR_W-1 -: OPC_W] == HLT_OPC;
    assign do_fetch   = redirect_valid || (state == RUN && !stall);

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state       <= RUN;
            pc          <= '0;
            if_id_valid <= 1'b0;
            if_id_pc    <= '0;
            if_id_instr <= NOP_WORD;
            pc_fault    <= 1'b0;
        end else if (do_fetch) begin
            if_id_valid <= 1'b1;
            if_id_pc    <= fetch_pc;
            if_id_instr <= fetch_word;
            pc          <= fetch_pc + PC_W'(1);
            state       <= fetch_hlt ? HALT : RUN;
            if (fetch_oor) begin
                pc_fault <= 1'b1;
            end
        end else if (state == HALT && !stall) begin
            // The held HLT has been consumed by decode; present a bubble from now on.
            if_id_valid <= 1'b0;
        end
    end

    assign halted = (state == HALT);

endmodule

// File: tb/tb_fetch_unit.sv
// Directed, table-driven bench for fetch_unit with DEPTH=8, plus hand sequences
// for same-cycle write/fetch, halt via redirect and reset during stall.
module tb_fetch_unit;

    localparam logic [31:0] NOP  = 32'h3800_0000;
    localparam logic [31:0] HLT  = 32'h3400_0055;
    localparam logic [31:0] HLT2 = 32'h3400_0066;

    logic        clock = 1'b0;
    logic        reset;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_we;
    logic [2:0]  imem_waddr;
    logic [31:0] imem_wdata;
    logic        if_id_valid;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_instr;
    logic [31:0] pc;
    logic        halted;
    logic        pc_fault;

    int n_cmp = 0;
    int n_bad = 0;

    fetch_unit #(.DEPTH(8)) dut (
        .clock          (clock),
        .reset          (reset),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_we        (imem_we),
        .imem_waddr     (imem_waddr),
        .imem_wdata     (imem_wdata),
        .if_id_valid    (if_id_valid),
        .if_id_pc       (if_id_pc),
        .if_id_instr    (if_id_instr),
        .pc             (pc),
        .halted         (halted),
        .pc_fault       (pc_fault)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic        stall;
        logic        rv;
        logic [31:0] rpc;
        logic        v;
        logic        chk;    // compare IF/ID pc/instr only when they are meaningful
        logic [31:0] ipc;
        logic [31:0] ins;
        logic [31:0] pc;
        logic        h;
        logic        f;
    } vec_t;

    vec_t tbl[$];

    function automatic logic [31:0] w(input int i);
        return 32'hA000_0100 + 32'(i);
    endfunction

    function automatic vec_t mk(input logic s, input logic rv, input logic [31:0] rpc,
                                input logic v, input logic chk, input logic [31:0] ipc,
                                input logic [31:0] ins, input logic [31:0] npc,
                                input logic h, input logic f);
        vec_t r;
        r.stall = s; r.rv = rv; r.rpc = rpc; r.v = v; r.chk = chk;
        r.ipc = ipc; r.ins = ins; r.pc = npc; r.h = h; r.f = f;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check_all(input string tag, input logic v, input logic chk,
                             input logic [31:0] ipc, input logic [31:0] ins,
                             input logic [31:0] npc, input logic h, input logic f);
        check({tag, ".valid"}, 32'(if_id_valid), 32'(v));
        if (chk) begin
            check({tag, ".if_id_pc"}, if_id_pc, ipc);
            check({tag, ".if_id_instr"}, if_id_instr, ins);
        end
        check({tag, ".pc"}, pc, npc);
        check({tag, ".halted"}, 32'(halted), 32'(h));
        check({tag, ".pc_fault"}, 32'(pc_fault), 32'(f));
    endtask

    initial begin
        reset = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        imem_we = 1'b0; imem_waddr = '0; imem_wdata = '0;

        // Load the program while reset is held; HLT sits at address 5.
        for (int i = 0; i < 8; i++) begin
            imem_we    = 1'b1;
            imem_waddr = 3'(i);
            imem_wdata = (i == 5) ? HLT : w(i);
            step();
        end
        imem_we = 1'b0;
        check_all("reset", 1'b0, 1'b1, 32'h0, NOP, 32'h0, 1'b0, 1'b0);

        //            stall rv  rpc           v  chk ipc           ins    pc   h  f
        tbl.push_back(mk(0, 0, 32'h0,        1, 1, 32'h0,        w(0), 32'h1, 0, 0));
        tbl.push_back(mk(0, 0, 32'h0,        1, 1, 32'h1,        w(1), 32'h2, 0, 0));
        tbl.push_back(mk(0, 0, 32'h0,        1, 1, 32'h2,        w(2), 32'h3, 0, 0));
        tbl.push_back(mk(1, 0, 32'h0,        1, 1, 32'h2,        w(2), 32'h3, 0, 0));
        tbl.push_back(mk(1, 0, 32'h0,        1, 1, 32'h2,        w(2), 32'h3, 0, 0));
        tbl.push_back(mk(1, 0, 32'h0,        1, 1, 32'h2,        w(2), 32'h3, 0, 0));
        tbl.push_back(mk(0, 0, 32'h0,        1, 1, 32'h3,        w(3), 32'h4, 0, 0));
        tbl.push_back(mk(0, 0, 32'h0,        1, 1, 32'h4,        w(4), 32'h5, 0, 0));
        tbl.push_back(mk(1, 0, 32'h0,        1, 1, 32'h4,        w(4), 32'h5, 0, 0));
        tbl.push_back(mk(1, 1, 32'h1,        1, 1, 32'h1,        w(1), 32'h2, 0, 0));
        tbl.push_back(mk(0, 0, 32'h0,        1, 1, 32'h2,        w(2), 32'h3, 0, 0));
        tbl.push_back(mk(0, 0, 32'h0,        1, 1, 32'h3,        w(3), 32'h4, 0, 0));
        tbl.push_back(mk(0, 0, 32'h0,        1, 1, 32'h4,        w(4), 32'h5, 0, 0));
        tbl.push_back(mk(0, 0, 32'h0,        1, 1, 32'h5,        HLT,  32'h6, 1, 0));
        tbl.push_back(mk(1, 0, 32'h0,        1, 1, 32'h5,        HLT,  32'h6, 1, 0));
        tbl.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,        NOP,  32'h6, 1, 0));
        tbl.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,        NOP,  32'h6, 1, 0));
        tbl.push_back(mk(0, 1, 32'h0,        1, 1, 32'h0,        w(0), 32'h1, 0, 0));
        tbl.push_back(mk(0, 1, 32'h6,        1, 1, 32'h6,        w(6), 32'h7, 0, 0));
        tbl.push_back(mk(0, 0, 32'h0,        1, 1, 32'h7,        w(7), 32'h8, 0, 0));
        tbl.push_back(mk(0, 0, 32'h0,        1, 1, 32'h8,        NOP,  32'h9, 0, 1));
        tbl.push_back(mk(0, 0, 32'h0,        1, 1, 32'h9,        NOP,  32'hA, 0, 1));
        tbl.push_back(mk(0, 1, 32'h2,        1, 1, 32'h2,        w(2), 32'h3, 0, 1));
        tbl.push_back(mk(0, 1, 32'hFFFF_FFFF, 1, 1, 32'hFFFF_FFFF, NOP, 32'h0, 0, 1));
        tbl.push_back(mk(0, 0, 32'h0,        1, 1, 32'h0,        w(0), 32'h1, 0, 1));
        tbl.push_back(mk(1, 1, 32'h5,        1, 1, 32'h5,        HLT,  32'h6, 1, 1));
        tbl.push_back(mk(1, 0, 32'h0,        1, 1, 32'h5,        HLT,  32'h6, 1, 1));
        tbl.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,        NOP,  32'h6, 1, 1));

        reset = 1'b1;
        foreach (tbl[i]) begin
            stall          = tbl[i].stall;
            redirect_valid = tbl[i].rv;
            redirect_pc    = tbl[i].rpc;
            step();
            check_all($sformatf("vec%0d", i), tbl[i].v, tbl[i].chk, tbl[i].ipc,
                      tbl[i].ins, tbl[i].pc, tbl[i].h, tbl[i].f);
        end

        // Write to the address being fetched in the same cycle: old word is fetched.
        stall = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h6;
        imem_we = 1'b1; imem_waddr = 3'd6; imem_wdata = HLT2;
        step();
        imem_we = 1'b0;
        check_all("wr_same", 1'b1, 1'b1, 32'h6, w(6), 32'h7, 1'b0, 1'b1);

        // New word now visible, and it halts.
        step();
        redirect_valid = 1'b0;
        check_all("wr_new", 1'b1, 1'b1, 32'h6, HLT2, 32'h7, 1'b1, 1'b1);

        // Reset while halted at pc=7 and stalled wins over everything.
        reset = 1'b0; stall = 1'b1;
        step();
        check_all("rst_mid", 1'b0, 1'b1, 32'h0, NOP, 32'h0, 1'b0, 1'b0);

        // Memory survives reset.
        reset = 1'b1; stall = 1'b0;
        step();
        check_all("post_rst", 1'b1, 1'b1, 32'h0, w(0), 32'h1, 1'b0, 1'b0);
        redirect_valid = 1'b1; redirect_pc = 32'h4;
        step();
        redirect_valid = 1'b0;
        check_all("mem_keep", 1'b1, 1'b1, 32'h4, w(4), 32'h5, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
